stopwatch_ctrl: RTL

- MM:SS stopwatch controller. It sequences a cascade of BCD digit counters: seconds-ones mod 10, seconds-tens mod 6, minutes-ones mod 10, minutes-tens mod 6.
- Generates the 1-per-TICK_DIV tick, the per-digit count enables and the clears.
- Run/pause/lap state machine.
- Feeds the 4-digit seven-segment display driver in the lab top level.

---
 rtl/stopwatch_pkg.sv | 38 +++
 rtl/bcd_digit_cnt.sv | 32 +++
 rtl/stopwatch_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
// Optional behaviour: STOPWATCH_AUTOSTOP_EN (see stopwatch_ctrl.sv).
package stopwatch_pkg;

    // Controller states; the encoding is visible on the debug output.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    // One BCD digit.
    typedef logic [3:0] bcd_t;

    // A full MM:SS reading, most significant digit first.
    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

    // Modulus of each digit in the cascade.
    localparam int SEC_ONES_MOD = 10;
    localparam int SEC_TENS_MOD = 6;
    localparam int MIN_ONES_MOD = 10;
    localparam int MIN_TENS_MOD = 6;

    // True when the reading is the last representable value, 59:59.
    function automatic logic is_last(input mmss_t t);
        return (t.sec_ones == bcd_t'(SEC_ONES_MOD - 1)) &&
               (t.sec_tens == bcd_t'(SEC_TENS_MOD - 1)) &&
               (t.min_ones == bcd_t'(MIN_ONES_MOD - 1)) &&
               (t.min_tens == bcd_t'(MIN_TENS_MOD - 1));
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counter with modulus MOD. The terminal-count output is
// qualified by CE so it can directly enable the next digit in a cascade.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic CLK,
    input  logic R,
    input  logic CLR,
    input  logic CE,
    output bcd_t Q,
    output logic TC
);

    localparam bcd_t LAST = bcd_t'(MOD - 1);

    // Digit register: synchronous clear wins over the count enable.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            Q <= '0;
        end else if (CLR) begin
            Q <= '0;
        end else if (CE) begin
            Q <= (Q == LAST) ? '0 : Q + 4'd1;
        end
    end

    // Carry into the next digit: this digit is enabled and about to wrap.
    assign TC = CE & (Q == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller: prescaler, run/pause/lap state machine,
// four cascaded BCD digit counters and a lap snapshot for the display.
//
// Control inputs SS_P, CLR_P and LAP_P are single-cycle pulses sampled on
// every rising CLK edge; there is no handshake or backpressure, a pulse is
// acted on in the cycle it is high or dropped (priority CLR_P > SS_P > LAP_P).
//
// Optional behaviour: define STOPWATCH_AUTOSTOP_EN to make the count stop
// at 59:59 (forced PAUSE, OVF set) instead of wrapping to 00:00.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100000000  // CLK cycles per count tick, >= 2
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       SS_P,
    input  logic       CLR_P,
    input  logic       LAP_P,
    output logic [3:0] D0,
    output logic [3:0] D1,
    output logic [3:0] D2,
    output logic [3:0] D3,
    output logic       RUNNING,
    output logic       TICK,
    output logic       OVF,
    output state_t     dbg_state
);

    localparam int            PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    state_t        state_q;
    state_t        state_nxt;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_nxt;
    mmss_t         snap_q;
    logic          ovf_q;

    logic          counting;
    logic          tick;
    logic          ce0;
    logic          tc0;
    logic          tc1;
    logic          tc2;
    logic          tc3;
    logic          stop_hit;
    logic          resume_blk;
    logic          snap_load;
    logic          ovf_set;

    bcd_t          q0;
    bcd_t          q1;
    bcd_t          q2;
    bcd_t          q3;
    mmss_t         live;
    mmss_t         disp;

    assign counting = (state_q == RUN) || (state_q == LAP);
    assign tick     = counting && (pre_q == PRE_MAX);
    assign live     = '{min_tens: q3, min_ones: q2, sec_tens: q1, sec_ones: q0};

`ifdef STOPWATCH_AUTOSTOP_EN
    logic at_last;
    assign at_last    = is_last(live);
    // The tick that would wrap 59:59 is turned into a stop instead.
    assign stop_hit   = tick && at_last;
    assign ce0        = tick && !at_last;
    // A stopped-at-limit count can only be recovered by a clear.
    assign resume_blk = at_last;
`else
    assign stop_hit   = 1'b0;
    assign ce0        = tick;
    assign resume_blk = 1'b0;
`endif

    // Overflow is flagged on the wrap (or on the forced stop at the limit).
    assign ovf_set = tc3 | stop_hit;

    // Next-state logic: clear first, then the limit stop, then the pulses.
    always_comb begin
        state_nxt = state_q;
        snap_load = 1'b0;
        if (CLR_P) begin
            state_nxt = IDLE;
        end else if (stop_hit) begin
            state_nxt = PAUSE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (SS_P) state_nxt = RUN;
                end
                RUN: begin
                    if (SS_P) begin
                        state_nxt = PAUSE;
                    end else if (LAP_P) begin
                        state_nxt = LAP;
                        snap_load = 1'b1;
                    end
                end
                PAUSE: begin
                    if (SS_P && !resume_blk) state_nxt = RUN;
                end
                LAP: begin
                    if (SS_P) begin
                        state_nxt = PAUSE;
                    end else if (LAP_P) begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Prescaler next value: zero in IDLE, count while running, hold in PAUSE.
    always_comb begin
        pre_nxt = pre_q;
        if (CLR_P || (state_q == IDLE)) begin
            pre_nxt = '0;
        end else if (counting) begin
            pre_nxt = tick ? '0 : pre_q + PW'(1);
        end
    end

    // State and prescaler registers.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
            pre_q   <= '0;
        end else begin
            state_q <= state_nxt;
            pre_q   <= pre_nxt;
        end
    end

    // Lap snapshot: captures the live count as seen in the LAP_P cycle.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            snap_q <= '0;
        end else if (CLR_P) begin
            snap_q <= '0;
        end else if (snap_load) begin
            snap_q <= live;
        end
    end

    // Sticky overflow flag; only a clear or reset removes it.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            ovf_q <= 1'b0;
        end else if (CLR_P) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end
    end

    bcd_digit_cnt #(.MOD(SEC_ONES_MOD)) u_sec_ones (
        .CLK (CLK),
        .R   (R),
        .CLR (CLR_P),
        .CE  (ce0),
        .Q   (q0),
        .TC  (tc0)
    );

    bcd_digit_cnt #(.MOD(SEC_TENS_MOD)) u_sec_tens (
        .CLK (CLK),
        .R   (R),
        .CLR (CLR_P),
        .CE  (tc0),
        .Q   (q1),
        .TC  (tc1)
    );

    bcd_digit_cnt #(.MOD(MIN_ONES_MOD)) u_min_ones (
        .CLK (CLK),
        .R   (R),
        .CLR (CLR_P),
        .CE  (tc1),
        .Q   (q2),
        .TC  (tc2)
    );

    bcd_digit_cnt #(.MOD(MIN_TENS_MOD)) u_min_tens (
        .CLK (CLK),
        .R   (R),
        .CLR (CLR_P),
        .CE  (tc2),
        .Q   (q3),
        .TC  (tc3)
    );

    // Display source: frozen snapshot while in LAP, live count otherwise.
    assign disp      = (state_q == LAP) ? snap_q : live;
    assign D0        = disp.sec_ones;
    assign D1        = disp.sec_tens;
    assign D2        = disp.min_ones;
    assign D3        = disp.min_tens;
    assign RUNNING   = counting;
    assign TICK      = tick;
    assign OVF       = ovf_q;
    assign dbg_state = state_q;

endmodule
